pipeline_ctrl: RTL and testbench

//  Parametrised hazard/pipeline-control unit for the lc3b in-order pipeline. Tracks per-stage valid

---
 rtl/lc3b_types.sv | 27 ++
 rtl/sat_counter.sv | 20 ++
 rtl/pipeline_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared types for the lc3b pipeline control slice.
package lc3b_types;

  typedef logic [2:0] lc3b_fwd_sel;

  localparam int unsigned STAGE_IF = 0;
  localparam int unsigned STAGE_ID = 1;

  // Widest register address carried in a stage record; narrower REG_W values are zero-extended.
  localparam int unsigned LC3B_DEST_W = 8;

  typedef struct packed {
    logic                   valid;
    logic [LC3B_DEST_W-1:0] dest;
    logic                   wr;
    logic                   load;
  } lc3b_pipe_rec;

  // What the pipeline does at the coming edge, in priority order.
  typedef enum logic [1:0] {
    CTRL_ADVANCE,
    CTRL_BUBBLE,
    CTRL_FLUSH,
    CTRL_FREEZE
  } lc3b_ctrl_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, cleared by the asynchronous active-low reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc and hold at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard / pipeline-control unit: per-stage valids, in-flight destinations,
// buffer load enables, load-use bubbles, branch flushes and forward selects.
module pipeline_ctrl
  import lc3b_types::*;
#(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned REG_W      = 3,
  parameter int unsigned BR_STAGE   = 3,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_stall_i,
  input  logic                  mem_stall_i,
  input  logic [REG_W-1:0]      id_src1_i,
  input  logic [REG_W-1:0]      id_src2_i,
  input  logic                  id_use1_i,
  input  logic                  id_use2_i,
  input  logic [REG_W-1:0]      id_dest_i,
  input  logic                  id_wr_i,
  input  logic                  id_load_i,
  input  logic                  br_taken_i,
  output logic [NUM_STAGES-1:0] stage_load_o,
  output logic [NUM_STAGES-1:0] stage_valid_o,
  output logic                  flush_o,
  output lc3b_fwd_sel           fwd1_o,
  output lc3b_fwd_sel           fwd2_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  localparam int unsigned LAST = NUM_STAGES - 1;

  logic [1:0]   front_valid;          // IF and ID valid bits
  lc3b_pipe_rec rec [2:LAST];         // records for stages 2..WB
  lc3b_pipe_rec id_rec;
  logic [LAST:2] match1, match2;
  logic          freeze, hazard, stall_inc;
  lc3b_ctrl_e    action;

  assign id_rec = '{valid: front_valid[STAGE_ID], dest: LC3B_DEST_W'(id_dest_i),
                    wr: id_wr_i, load: id_load_i};

  // A stage matches a source when it holds a valid writer of that register.
  for (genvar k = 2; k < NUM_STAGES; k++) begin : g_cmp
    assign match1[k] = rec[k].valid & rec[k].wr & (rec[k].dest == LC3B_DEST_W'(id_src1_i));
    assign match2[k] = rec[k].valid & rec[k].wr & (rec[k].dest == LC3B_DEST_W'(id_src2_i));
  end

  assign freeze    = if_stall_i | mem_stall_i;
  assign flush_o   = br_taken_i & rec[BR_STAGE].valid & ~freeze;
  assign stall_inc = freeze | (action == CTRL_BUBBLE);

  // RAW hazard seen by the instruction in ID.
  always_comb begin
    hazard = 1'b0;
    if (front_valid[STAGE_ID]) begin
      if (FWD_EN != 0) begin
        hazard = rec[2].load & ((id_use1_i & match1[2]) | (id_use2_i & match2[2]));
      end else begin
        // WB is left out: the regfile writes through to the ID read.
        for (int unsigned k = 2; k < LAST; k++) begin
          if ((id_use1_i && match1[k]) || (id_use2_i && match2[k])) hazard = 1'b1;
        end
      end
    end
  end

  // Forward select: scan from WB down so the lowest matching stage wins.
  always_comb begin
    fwd1_o = '0;
    fwd2_o = '0;
    if ((FWD_EN != 0) && front_valid[STAGE_ID] && !hazard) begin
      for (int unsigned k = LAST; k >= 2; k--) begin
        if (match1[k]) fwd1_o = lc3b_fwd_sel'(k);
        if (match2[k]) fwd2_o = lc3b_fwd_sel'(k);
      end
    end
  end

  // Resolve this cycle's action: freeze > flush > bubble > advance.
  always_comb begin
    if (freeze)       action = CTRL_FREEZE;
    else if (flush_o) action = CTRL_FLUSH;
    else if (hazard)  action = CTRL_BUBBLE;
    else              action = CTRL_ADVANCE;
  end

  // Buffer load enables; forced low while reset is asserted.
  always_comb begin
    stage_load_o = '0;
    if (rst_n) begin
      case (action)
        CTRL_FREEZE: stage_load_o = '0;
        CTRL_BUBBLE: begin
          stage_load_o           = '1;
          stage_load_o[STAGE_IF] = 1'b0;
          stage_load_o[STAGE_ID] = 1'b0;
        end
        default:     stage_load_o = '1;
      endcase
    end
  end

  // Gather valid bits from IF/ID and the stage records.
  always_comb begin
    stage_valid_o = '0;
    stage_valid_o[STAGE_IF] = front_valid[STAGE_IF];
    stage_valid_o[STAGE_ID] = front_valid[STAGE_ID];
    for (int unsigned k = 2; k < NUM_STAGES; k++) stage_valid_o[k] = rec[k].valid;
  end

  // Pipeline state: shift records according to the resolved action.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_valid <= '0;
      for (int unsigned k = 2; k < NUM_STAGES; k++) rec[k] <= '0;
    end else begin
      case (action)
        CTRL_FLUSH: begin
          // Stage 2 is always inside the flushed range, so it is cleared outside the loop.
          front_valid <= 2'b01;
          rec[2]      <= '0;
          for (int unsigned k = 3; k < NUM_STAGES; k++) begin
            if (k <= BR_STAGE) rec[k] <= '0;
            else               rec[k] <= rec[k-1];
          end
        end
        CTRL_BUBBLE: begin
          rec[2] <= '0;
          for (int unsigned k = 3; k < NUM_STAGES; k++) rec[k] <= rec[k-1];
        end
        CTRL_ADVANCE: begin
          front_valid <= {front_valid[STAGE_IF], 1'b1};
          rec[2]      <= id_rec;
          for (int unsigned k = 3; k < NUM_STAGES; k++) rec[k] <= rec[k-1];
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_o),
    .count (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two configurations driven from shared stimulus,
// each checked every cycle against a slot-array model of the pipeline.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic if_stall_i = 0, mem_stall_i = 0, id_use1_i = 0, id_use2_i = 0;
  logic id_wr_i = 0, id_load_i = 0, br_taken_i = 0;
  logic [2:0] id_src1_i = 0, id_src2_i = 0, id_dest_i = 0;

  logic [4:0]  load0, valid0;
  logic        flush0;
  logic [2:0]  f10, f20;
  logic [15:0] sc0, fc0;
  logic [5:0]  load1, valid1;
  logic        flush1;
  logic [2:0]  f11, f21;
  logic [3:0]  sc1, fc1;

  pipeline_ctrl #(.NUM_STAGES(5), .REG_W(3), .BR_STAGE(3), .FWD_EN(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .if_stall_i(if_stall_i), .mem_stall_i(mem_stall_i),
    .id_src1_i(id_src1_i), .id_src2_i(id_src2_i), .id_use1_i(id_use1_i), .id_use2_i(id_use2_i),
    .id_dest_i(id_dest_i), .id_wr_i(id_wr_i), .id_load_i(id_load_i), .br_taken_i(br_taken_i),
    .stage_load_o(load0), .stage_valid_o(valid0), .flush_o(flush0), .fwd1_o(f10), .fwd2_o(f20),
    .stall_cnt_o(sc0), .flush_cnt_o(fc0));

  pipeline_ctrl #(.NUM_STAGES(6), .REG_W(3), .BR_STAGE(3), .FWD_EN(0), .CNT_W(4)) dut_nofwd (
    .clk(clk), .rst_n(rst_n), .if_stall_i(if_stall_i), .mem_stall_i(mem_stall_i),
    .id_src1_i(id_src1_i), .id_src2_i(id_src2_i), .id_use1_i(id_use1_i), .id_use2_i(id_use2_i),
    .id_dest_i(id_dest_i), .id_wr_i(id_wr_i), .id_load_i(id_load_i), .br_taken_i(br_taken_i),
    .stage_load_o(load1), .stage_valid_o(valid1), .flush_o(flush1), .fwd1_o(f11), .fwd2_o(f21),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model configuration per instance.
  int M_NS[2]  = '{5, 6};
  int M_BR[2]  = '{3, 3};
  bit M_FWD[2] = '{1'b1, 1'b0};
  int M_CW[2]  = '{16, 4};

  // Model state: one slot per stage holding an instruction summary.
  bit mv[2][8]; int md[2][8]; bit mw[2][8]; bit ml[2][8];
  bit nv[2][8]; int nd[2][8]; bit nw[2][8]; bit nl[2][8];
  int mstall[2], mflush[2], nstall[2], nflush[2];
  bit [7:0] e_load[2], e_valid[2];
  bit e_flush[2];
  int e_f1[2], e_f2[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit writes(int i, int k, int r);
    return mv[i][k] && mw[i][k] && (md[i][k] == r);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 8; k++) begin
        mv[i][k] = 0; md[i][k] = 0; mw[i][k] = 0; ml[i][k] = 0;
      end
      mstall[i] = 0; mflush[i] = 0;
    end
  endtask

  // Outputs for the current cycle plus the state after the coming edge.
  task automatic model_eval(input int i);
    int ns, br, s1, s2, f1, f2, smax;
    bit fz, fl, hz, bub, hit;
    bit [7:0] mask, vv;
    ns = M_NS[i]; br = M_BR[i];
    s1 = int'(id_src1_i); s2 = int'(id_src2_i);
    smax = (1 << M_CW[i]) - 1;
    fz = if_stall_i || mem_stall_i;
    fl = br_taken_i && mv[i][br] && !fz;
    hz = 0;
    if (mv[i][1]) begin
      for (int k = 2; k < ns; k++) begin
        hit = (id_use1_i && writes(i, k, s1)) || (id_use2_i && writes(i, k, s2));
        if (hit && (M_FWD[i] ? (k == 2 && ml[i][k]) : (k <= ns - 2))) hz = 1;
      end
    end
    f1 = 0; f2 = 0;
    if (M_FWD[i] && mv[i][1] && !hz) begin
      for (int k = ns - 1; k >= 2; k--) begin
        if (writes(i, k, s1)) f1 = k;
        if (writes(i, k, s2)) f2 = k;
      end
    end
    bub = !fz && !fl && hz;
    mask = 8'((1 << ns) - 1);
    e_load[i] = fz ? 8'd0 : (bub ? (mask & 8'hFC) : mask);
    vv = 0;
    for (int k = 0; k < ns; k++) vv[k] = mv[i][k];
    e_valid[i] = vv;
    e_flush[i] = fl; e_f1[i] = f1; e_f2[i] = f2;

    for (int k = 0; k < 8; k++) begin
      nv[i][k] = mv[i][k]; nd[i][k] = md[i][k]; nw[i][k] = mw[i][k]; nl[i][k] = ml[i][k];
    end
    if (!fz) begin
      for (int k = 3; k < ns; k++) begin
        nv[i][k] = mv[i][k-1]; nd[i][k] = md[i][k-1]; nw[i][k] = mw[i][k-1]; nl[i][k] = ml[i][k-1];
      end
      if (fl) begin
        for (int k = 1; k <= br; k++) nv[i][k] = 0;
        nv[i][0] = 1;
      end else if (bub) begin
        nv[i][2] = 0;
      end else begin
        nv[i][2] = mv[i][1]; nd[i][2] = int'(id_dest_i); nw[i][2] = id_wr_i; nl[i][2] = id_load_i;
        nv[i][1] = mv[i][0];
        nv[i][0] = 1;
      end
    end
    nstall[i] = ((fz || bub) && mstall[i] < smax) ? mstall[i] + 1 : mstall[i];
    nflush[i] = (fl && mflush[i] < smax) ? mflush[i] + 1 : mflush[i];
  endtask

  task automatic compare(input int i);
    logic [7:0] a_load, a_valid;
    logic a_flush;
    logic [2:0] a_f1, a_f2;
    logic [31:0] a_sc, a_fc;
    if (i == 0) begin
      a_load = 8'(load0); a_valid = 8'(valid0); a_flush = flush0; a_f1 = f10; a_f2 = f20;
      a_sc = 32'(sc0); a_fc = 32'(fc0);
    end else begin
      a_load = 8'(load1); a_valid = 8'(valid1); a_flush = flush1; a_f1 = f11; a_f2 = f21;
      a_sc = 32'(sc1); a_fc = 32'(fc1);
    end
    chk($sformatf("u%0d stage_load", i), 32'(a_load), 32'(e_load[i]));
    chk($sformatf("u%0d stage_valid", i), 32'(a_valid), 32'(e_valid[i]));
    chk($sformatf("u%0d flush", i), 32'(a_flush), 32'(e_flush[i]));
    chk($sformatf("u%0d fwd1", i), 32'(a_f1), e_f1[i]);
    chk($sformatf("u%0d fwd2", i), 32'(a_f2), e_f2[i]);
    chk($sformatf("u%0d stall_cnt", i), a_sc, mstall[i]);
    chk($sformatf("u%0d flush_cnt", i), a_fc, mflush[i]);
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      model_eval(i);
      compare(i);
    end
    @(posedge clk);
    mv = nv; md = nd; mw = nw; ml = nl; mstall = nstall; mflush = nflush;
    #1;
  endtask

  task automatic idle_inputs();
    if_stall_i = 0; mem_stall_i = 0; id_use1_i = 0; id_use2_i = 0;
    id_wr_i = 0; id_load_i = 0; br_taken_i = 0;
    id_src1_i = 0; id_src2_i = 0; id_dest_i = 0;
  endtask

  task automatic set_id(input int dest, input bit wr, input bit ld,
                        input bit u1, input int s1, input bit u2, input int s2);
    id_dest_i = 3'(dest); id_wr_i = wr; id_load_i = ld;
    id_use1_i = u1; id_src1_i = 3'(s1); id_use2_i = u2; id_src2_i = 3'(s2);
  endtask

  int s0_base, s1_base, nbub;

  initial begin
    model_reset();
    idle_inputs();
    #3;
    chk("reset valid0", 32'(valid0), 0);
    chk("reset load0", 32'(load0), 0);
    chk("reset load1", 32'(load1), 0);
    chk("reset flush0", 32'(flush0), 0);
    chk("reset fwd0", 32'({f10, f20}), 0);
    chk("reset cnt0", 32'({sc0, fc0}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill from empty with no hazards.
    for (int c = 0; c < 6; c++) begin
      step();
      chk("fill valid0", 32'(valid0), (c >= 4) ? 31 : ((2 << c) - 1));
      chk("fill load0", 32'(load0), 31);
    end

    // LDR R1; ADD R2,R1,R3 -> one bubble, then forward from stage 3.
    set_id(1, 1, 1, 0, 0, 0, 0);
    step();
    set_id(2, 1, 0, 1, 1, 1, 3);
    #1;
    chk("lu bubble load0", 32'(load0), 5'b11100);
    step();
    chk("lu valid2 cleared", 32'(valid0[2]), 0);
    chk("lu load0 after", 32'(load0), 31);
    chk("lu fwd1", 32'(f10), 3);
    chk("lu fwd2", 32'(f20), 0);
    chk("lu stall_cnt0", 32'(sc0), 1);
    step();
    idle_inputs();
    for (int c = 0; c < 6; c++) step();

    // ADD R1; ADD R4,R1,R1 -> forward from stage 2, or 3 bubbles without forwarding.
    s0_base = int'(sc0); s1_base = int'(sc1);
    set_id(1, 1, 0, 0, 0, 0, 0);
    step();
    set_id(4, 1, 0, 1, 1, 1, 1);
    #1;
    chk("alu fwd1", 32'(f10), 2);
    chk("alu fwd2", 32'(f20), 2);
    chk("alu load0", 32'(load0), 31);
    nbub = 0;
    for (int c = 0; c < 6; c++) begin
      if (load1[1:0] == 2'b00) nbub++;
      step();
    end
    chk("nofwd bubbles", nbub, 3);
    chk("nofwd stall delta", int'(sc1) - s1_base, 3);
    chk("fwd stall delta", int'(sc0) - s0_base, 0);
    idle_inputs();
    for (int c = 0; c < 6; c++) step();

    // Taken branch in stage 3 overrides a load-use hazard in ID.
    set_id(1, 1, 1, 0, 0, 0, 0);
    step();
    set_id(2, 1, 0, 1, 1, 1, 3);
    br_taken_i = 1;
    #1;
    chk("br flush0", 32'(flush0), 1);
    chk("br load0", 32'(load0), 31);
    step();
    chk("br valid0", 32'(valid0), 5'b10001);
    chk("br flush_cnt0", 32'(fc0), 1);
    idle_inputs();
    for (int c = 0; c < 4; c++) step();

    // mem_stall held 4 cycles with a taken branch waiting in stage 3.
    s0_base = int'(sc0);
    mem_stall_i = 1; br_taken_i = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("frz load0", 32'(load0), 0);
      chk("frz flush0", 32'(flush0), 0);
      step();
    end
    mem_stall_i = 0;
    #1;
    chk("frz release flush0", 32'(flush0), 1);
    step();
    chk("frz stall delta", int'(sc0) - s0_base, 4);
    chk("frz flush_cnt0", 32'(fc0), 2);
    idle_inputs();

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      if_stall_i  = ($urandom_range(0, 9) == 0);
      mem_stall_i = ($urandom_range(0, 11) == 0);
      br_taken_i  = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 3), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), $urandom_range(0, 3));
      step();
    end
    idle_inputs();
    for (int c = 0; c < 3; c++) step();

    // Long freeze saturates the 4-bit counter; async reset mid-freeze.
    mem_stall_i = 1;
    for (int c = 0; c < 20; c++) step();
    chk("sat stall_cnt1", 32'(sc1), 15);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst valid0", 32'(valid0), 0);
    chk("mid rst valid1", 32'(valid1), 0);
    chk("mid rst cnt0", 32'({sc0, fc0}), 0);
    chk("mid rst cnt1", 32'({sc1, fc1}), 0);
    chk("mid rst load1", 32'(load1), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_stall_i = 0;
    for (int c = 0; c < 10; c++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
